fifo_4x8: RTL and testbench



---
 rtl/fifo_4x8.sv | 69 ++++++
 tb/tb_fifo_4x8.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifo_4x8.sv
// fifo_4x8: single-clock byte FIFO with registered read data.
// Status flags are decoded from an occupancy counter.
module fifo_4x8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign data_out = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_fifo_4x8.sv
// tb_fifo_4x8: directed plus random stimulus against a queue model.
module tb_fifo_4x8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout = 8'h00;

    fifo_4x8 #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 4));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    endtask

    // One clock: drive, step the model with pre-edge occupancy, check.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input string tag);
        bit dw, dr;
        wr_en = w;
        rd_en = r;
        data_in = d;
        dw = w && (q.size() < 4);
        dr = r && (q.size() > 0);
        @(posedge clk);
        if (dr) exp_dout = q.pop_front();
        if (dw) q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        #3;
        chk_all("rst_low");
        chk("rst_cnt0", 32'(q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 8'h00, "idle0");
        cyc(0, 0, 8'h00, "idle1");

        cyc(1, 0, 8'hAA, "fill0");
        cyc(1, 0, 8'hF0, "fill1");
        cyc(1, 0, 8'h0F, "fill2");
        cyc(1, 0, 8'h55, "fill3");
        chk("full_after4", 32'(full), 32'd1);
        cyc(1, 0, 8'h77, "wr_full");

        cyc(0, 1, 8'h00, "rd_aa");
        chk("dout_aa", 32'(data_out), 32'hAA);
        cyc(0, 1, 8'h00, "rd_f0");
        chk("dout_f0", 32'(data_out), 32'hF0);
        cyc(1, 0, 8'hCC, "wr_cc_wrap");

        cyc(0, 1, 8'h00, "rd_0f");
        cyc(0, 1, 8'h00, "rd_55");
        cyc(0, 1, 8'h00, "rd_cc");
        chk("dout_cc", 32'(data_out), 32'hCC);
        cyc(0, 1, 8'h00, "rd_empty");
        chk("dout_hold_cc", 32'(data_out), 32'hCC);

        cyc(1, 0, 8'h11, "pre2_a");
        cyc(1, 0, 8'h22, "pre2_b");
        cyc(1, 1, 8'h3C, "both_mid");
        chk("both_mid_old", 32'(data_out), 32'h11);
        cyc(0, 1, 8'h00, "drn_22");
        cyc(0, 1, 8'h00, "drn_3c");
        chk("dout_3c", 32'(data_out), 32'h3C);

        cyc(1, 1, 8'h99, "both_empty");
        chk("both_empty_hold", 32'(data_out), 32'h3C);
        cyc(1, 0, 8'h98, "f1");
        cyc(1, 0, 8'h97, "f2");
        cyc(1, 0, 8'h96, "f3");
        cyc(1, 1, 8'h95, "both_full");
        chk("both_full_rd", 32'(data_out), 32'h99);

        cyc(0, 1, 8'h00, "to3");
        #2;
        rst_n = 1'b0;
        q.delete();
        exp_dout = 8'h00;
        #1;
        chk_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 8'h5A, "wr_5a");
        cyc(0, 1, 8'h00, "rd_5a");
        chk("dout_5a", 32'(data_out), 32'h5A);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 55),
                1'($urandom_range(0, 99) < 50),
                8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
